// File: rtl/audio_pkg.sv
// Shared audio definitions: frame rate divider, playback states and slot timing helper.
package audio_pkg;

    localparam int unsigned DIV_44K1 = 640;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Counter value at which channel ch's RAM slot begins.
    function automatic int unsigned slot_offset(input int unsigned ch, input int unsigned rd_lat);
        return ch * (rd_lat + 1);
    endfunction

endpackage

// File: rtl/pcm_frame_fetcher_if.sv
// RAM read port plus published sample stream of the PCM frame fetcher.
interface pcm_frame_fetcher_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned NCH    = 2
);
    logic [3:0]            we_rd;
    logic                  en_rd;
    logic [ADDR_W-1:0]     addr_rd;
    logic [DATA_W-1:0]     din;
    logic [NCH*DATA_W-1:0] sample_out;
    logic                  fs_enb;

    modport master (
        output we_rd,
        output en_rd,
        output addr_rd,
        output sample_out,
        output fs_enb,
        input  din
    );

    modport slave (
        input  we_rd,
        input  en_rd,
        input  addr_rd,
        input  sample_out,
        input  fs_enb,
        output din
    );
endinterface

// File: rtl/pcm_frame_fetcher_frame_timer.sv
// Audio frame counter: counts 0..DIV-1 while run is high, clear forces it back to 0.
module frame_timer
    import audio_pkg::*;
#(
    parameter int unsigned DIV   = DIV_44K1,
    parameter int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tc
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tc    = (cnt_q == CNT_W'(DIV - 1));
    assign count = cnt_q;

endmodule

// File: rtl/pcm_frame_fetcher.sv
// Fetches NCH interleaved PCM words per audio frame from block RAM over a programmable
// address window and publishes them together with a one-cycle sample strobe.
module pcm_frame_fetcher
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned NCH    = 2,
    parameter int unsigned DIV    = DIV_44K1,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic                busy,
    output logic                done,
    pcm_frame_fetcher_if.master bus
);
    localparam int unsigned SLOT  = RD_LAT + 1;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned PUB   = NCH * SLOT + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt;
    logic                  tc;
    logic [ADDR_W-1:0]     wa_q, wb_q, cur_q, addr_q;
    logic                  lp_q, hit_q, done_q, fs_q;
    logic [NCH*DATA_W-1:0] shadow_q, sample_q;
    logic                  issue, publish, active, launch, timer_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && !stop) state_d = StRun;
            StRun:   if (stop || done_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
    end

    assign launch      = (state_q == StIdle) && start && !stop;
    // The retire cycle after a one-shot done behaves like a stop: nothing else advances.
    assign active      = (state_q == StRun) && !stop && !done_q;
    assign timer_clear = (state_q != StRun) || (state_d != StRun);

    frame_timer #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (busy),
        .clear (timer_clear),
        .count (cnt),
        .tc    (tc)
    );

    always_comb begin
        issue = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (cnt == CNT_W'(slot_offset(c, RD_LAT))) issue = 1'b1;
        end
    end

    assign publish = (cnt == CNT_W'(PUB));

    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q     <= '0;
            wb_q     <= '0;
            lp_q     <= 1'b0;
            cur_q    <= '0;
            addr_q   <= '0;
            hit_q    <= 1'b0;
            shadow_q <= '0;
            sample_q <= '0;
            fs_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fs_q   <= 1'b0;
            done_q <= 1'b0;
            if (launch) begin
                wa_q  <= start_addr;
                wb_q  <= end_addr;
                lp_q  <= loop_en;
                cur_q <= start_addr;
                hit_q <= 1'b0;
            end else if (active) begin
                if (issue) begin
                    addr_q <= cur_q;
                    cur_q  <= (cur_q == wb_q) ? wa_q : cur_q + ADDR_W'(1);
                    if (cur_q == wb_q) hit_q <= 1'b1;
                end else if (tc) begin
                    // hit_q marks a frame that touched the window end; reset it between frames
                    hit_q <= 1'b0;
                end
                for (int unsigned c = 0; c < NCH; c++) begin
                    if (cnt == CNT_W'(slot_offset(c + 1, RD_LAT))) begin
                        shadow_q[c*DATA_W +: DATA_W] <= bus.din;
                    end
                end
                if (publish) begin
                    sample_q <= shadow_q;
                    fs_q     <= 1'b1;
                    done_q   <= hit_q && !lp_q;
                end
            end
        end
    end

    assign bus.we_rd      = '0;
    assign bus.en_rd      = 1'b1;
    assign bus.addr_rd    = addr_q;
    assign bus.sample_out = sample_q;
    assign bus.fs_enb     = fs_q;
    assign done           = done_q;

endmodule

// File: tb/tb_pcm_frame_fetcher.sv
// Scoreboard bench for pcm_frame_fetcher: two configurations, window-level reference model.
module tb_pcm_frame_fetcher;
    localparam int DIV_A = 16, NCH_A = 2, LAT_A = 1, SLOT_A = 2;
    localparam int DIV_B = 32, NCH_B = 4, LAT_B = 3, SLOT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          t;
        logic [63:0] data;
        bit          dn;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic        rst_a = 1'b1, start_a = 1'b0, stop_a = 1'b0, loop_a = 1'b0;
    logic [10:0] sa_a = '0, ea_a = '0;
    logic        busy_a, done_a;
    logic        rst_b = 1'b1, start_b = 1'b0, stop_b = 1'b0, loop_b = 1'b0;
    logic [10:0] sa_b = '0, ea_b = '0;
    logic        busy_b, done_b;

    pcm_frame_fetcher_if #(.DATA_W(16), .ADDR_W(11), .NCH(NCH_A)) bus_a ();
    pcm_frame_fetcher_if #(.DATA_W(16), .ADDR_W(11), .NCH(NCH_B)) bus_b ();

    pcm_frame_fetcher #(
        .DATA_W(16), .ADDR_W(11), .NCH(NCH_A), .DIV(DIV_A), .RD_LAT(LAT_A)
    ) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a), .loop_en(loop_a),
        .start_addr(sa_a), .end_addr(ea_a), .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    pcm_frame_fetcher #(
        .DATA_W(16), .ADDR_W(11), .NCH(NCH_B), .DIV(DIV_B), .RD_LAT(LAT_B)
    ) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .loop_en(loop_b),
        .start_addr(sa_b), .end_addr(ea_b), .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    // RAM models: word(a) = 0x1000 + a, valid RD_LAT cycles after the address changes
    logic [10:0] pa;
    logic [10:0] pb [3];
    always @(posedge clk) begin
        pa    <= bus_a.addr_rd;
        pb[0] <= bus_b.addr_rd;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign bus_a.din = 16'h1000 + 16'(pa);
    assign bus_b.din = 16'h1000 + 16'(pb[2]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Reference: walk the window by index, NCH words per frame, one strobe per DIV cycles.
    function automatic void plan(input bit to_b, input int nch, input int slot, input int div,
                                 input int t_start, input logic [10:0] wa, input logic [10:0] wb,
                                 input bit lp, input int max_fr, output int t_last,
                                 output logic [63:0] last_data, output logic [10:0] last_addr);
        logic [10:0] diff, a;
        int          len, idx;
        exp_t        e;
        bit          hit;
        diff      = wb - wa;
        len       = int'(diff) + 1;
        idx       = 0;
        t_last    = t_start;
        last_data = '0;
        last_addr = '0;
        for (int k = 0; k < max_fr; k++) begin
            hit    = 1'b0;
            e.data = '0;
            for (int c = 0; c < nch; c++) begin
                a = wa + 11'(idx);
                e.data |= 64'(16'h1000 + 16'(a)) << (16 * c);
                if (idx == len - 1) hit = 1'b1;
                last_addr = a;
                idx = (idx + 1) % len;
            end
            e.t  = t_start + nch * slot + 2 + k * div;
            e.dn = !lp && hit;
            if (to_b) q_b.push_back(e);
            else q_a.push_back(e);
            t_last    = e.t;
            last_data = e.data;
            if (e.dn) break;
        end
    endfunction

    bit bl_a = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bl_a) begin
            bl_a = 1'b0;
            chk("busy_after_done_a", 64'(busy_a), 64'd0);
        end
        if (bus_a.fs_enb === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe_a: got strobe expected none at cycle %0d", cyc);
            end else begin
                e = q_a.pop_front();
                chk("strobe_time_a", 64'(cyc), 64'(e.t));
                chk("sample_a", 64'(bus_a.sample_out), e.data);
                chk("done_a", 64'(done_a), 64'(e.dn));
                if (e.dn) begin
                    chk("busy_at_done_a", 64'(busy_a), 64'd1);
                    bl_a = 1'b1;
                end
            end
        end else if (done_a !== 1'b0) begin
            chk("done_without_strobe_a", 64'(done_a), 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.fs_enb === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe_b: got strobe expected none at cycle %0d", cyc);
            end else begin
                e = q_b.pop_front();
                chk("strobe_time_b", 64'(cyc), 64'(e.t));
                chk("sample_b", 64'(bus_b.sample_out), e.data);
                chk("done_b", 64'(done_b), 64'(e.dn));
            end
        end else if (done_b !== 1'b0) begin
            chk("done_without_strobe_b", 64'(done_b), 64'd0);
        end
    end

    task automatic sess_a(input logic [10:0] wa, input logic [10:0] wb, input bit lp,
                          input int nfr, input bit poke);
        int          ts, tl;
        logic [63:0] ld;
        logic [10:0] la;
        @(negedge clk);
        sa_a = wa; ea_a = wb; loop_a = lp; start_a = 1'b1;
        ts = cyc + 1;
        plan(1'b0, NCH_A, SLOT_A, DIV_A, ts, wa, wb, lp, lp ? nfr : 10000, tl, ld, la);
        @(negedge clk);
        start_a = 1'b0;
        sa_a = 11'($urandom); ea_a = 11'($urandom); loop_a = 1'($urandom);
        chk("busy_after_start_a", 64'(busy_a), 64'd1);
        if (poke) begin
            @(negedge clk) start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
        end
        wait_cyc(tl + 3);
        if (lp) begin
            stop_a = 1'b1;
            @(negedge clk) stop_a = 1'b0;
            chk("busy_after_stop_a", 64'(busy_a), 64'd0);
            wait_cyc(cyc + DIV_A + 4);
            chk("sample_hold_after_stop_a", 64'(bus_a.sample_out), ld);
            chk("addr_hold_after_stop_a", 64'(bus_a.addr_rd), 64'(la));
        end else begin
            chk("busy_after_oneshot_a", 64'(busy_a), 64'd0);
            chk("addr_hold_after_oneshot_a", 64'(bus_a.addr_rd), 64'(la));
            chk("sample_after_oneshot_a", 64'(bus_a.sample_out), ld);
        end
        chk("queue_drained_a", 64'(q_a.size()), 64'd0);
    endtask

    task automatic sess_b(input logic [10:0] wa, input logic [10:0] wb, input bit lp,
                          input int nfr);
        int          ts, tl;
        logic [63:0] ld;
        logic [10:0] la;
        @(negedge clk);
        sa_b = wa; ea_b = wb; loop_b = lp; start_b = 1'b1;
        ts = cyc + 1;
        plan(1'b1, NCH_B, SLOT_B, DIV_B, ts, wa, wb, lp, lp ? nfr : 10000, tl, ld, la);
        @(negedge clk) start_b = 1'b0;
        wait_cyc(tl + 3);
        if (lp) begin
            stop_b = 1'b1;
            @(negedge clk) stop_b = 1'b0;
        end
        chk("busy_end_b", 64'(busy_b), 64'd0);
        chk("addr_hold_b", 64'(bus_b.addr_rd), 64'(la));
        chk("queue_drained_b", 64'(q_b.size()), 64'd0);
    endtask

    task automatic run_a();
        logic [10:0] wa;
        int          len;
        sess_a(11'd4, 11'd9, 1'b1, 4, 1'b0);
        sess_a(11'd4, 11'd9, 1'b0, 0, 1'b0);
        sess_a(11'd4, 11'd8, 1'b1, 4, 1'b1);
        // start and stop together from idle: must stay idle
        @(negedge clk);
        sa_a = 11'd4; ea_a = 11'd9; loop_a = 1'b1; start_a = 1'b1; stop_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; stop_a = 1'b0;
        chk("busy_start_stop_a", 64'(busy_a), 64'd0);
        repeat (DIV_A + 8) @(negedge clk);
        chk("busy_start_stop_late_a", 64'(busy_a), 64'd0);
        for (int i = 0; i < 6; i++) begin
            wa  = 11'($urandom);
            len = int'($urandom_range(1, 7));
            sess_a(wa, wa + 11'(len - 1), 1'($urandom), int'($urandom_range(1, 4)),
                   1'($urandom));
        end
        sess_a(11'h123, 11'h123, 1'b0, 0, 1'b0);
        sess_a(11'h123, 11'h123, 1'b1, 2, 1'b0);
        // reset in the middle of a frame, counter at 2
        @(negedge clk);
        sa_a = 11'd4; ea_a = 11'd9; loop_a = 1'b1; start_a = 1'b1;
        wa = 11'(cyc + 1);
        len = cyc + 1;
        @(negedge clk) start_a = 1'b0;
        wait_cyc(len + 2);
        rst_a = 1'b1;
        @(negedge clk) rst_a = 1'b0;
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_addr_a", 64'(bus_a.addr_rd), 64'd0);
        chk("rst_sample_a", 64'(bus_a.sample_out), 64'd0);
        chk("rst_fs_a", 64'(bus_a.fs_enb), 64'd0);
        chk("rst_done_a", 64'(done_a), 64'd0);
        repeat (DIV_A + 4) @(negedge clk);
        sess_a(11'h7FE, 11'h001, 1'b0, 0, 1'b0);
    endtask

    task automatic run_b();
        logic [10:0] wa;
        sess_b(11'h100, 11'h10A, 1'b1, 4);
        sess_b(11'h7FC, 11'h002, 1'b0, 0);
        wa = 11'($urandom);
        sess_b(wa, wa + 11'($urandom_range(0, 9)), 1'b0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_busy_a", 64'(busy_a), 64'd0);
        chk("reset_sample_a", 64'(bus_a.sample_out), 64'd0);
        chk("reset_addr_a", 64'(bus_a.addr_rd), 64'd0);
        chk("reset_en_we_a", {bus_a.en_rd, bus_a.we_rd}, 64'h10);
        chk("reset_busy_b", 64'(busy_b), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            run_a();
            run_b();
        join
        repeat (4) @(negedge clk);
        chk("final_queue_a", 64'(q_a.size()), 64'd0);
        chk("final_queue_b", 64'(q_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
